// File: rtl/mem_arb.sv
// Two-port (fetch/data) to one-port memory arbiter with data priority and a fetch-starvation streak limit.
// Optional feature: define MEM_ARB_REG_RESP_EN to register the response path (adds the RESP state).
module mem_arb #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] im_req_addr,
  input  logic        im_req_valid,
  output logic [63:0] im_resp_rdata,
  output logic        im_resp_valid,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic        bus_req_wen,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  input  logic [63:0] bus_resp_rdata,
  input  logic        bus_resp_valid,
  output logic [2:0]  dbg_state,
  output logic [2:0]  dbg_streak
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IREQ  = 3'd1,
    S_IWAIT = 3'd2,
    S_DREQ  = 3'd3,
    S_DWAIT = 3'd4
`ifdef MEM_ARB_REG_RESP_EN
    , S_RESP = 3'd5
`endif
  } state_t;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

  state_t      state_q, state_d;
  logic [2:0]  streak_q, streak_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        valid_q, valid_d;
  logic        d_wins;

`ifdef MEM_ARB_REG_RESP_EN
  logic [63:0] resp_data_q, resp_data_d;
  logic        im_rv_q, im_rv_d;
  logic        dm_rv_q, dm_rv_d;
`endif

  // Data wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
  assign d_wins = dm_req_valid && !(im_req_valid && (streak_q == STREAK_MAX));

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    valid_d  = valid_q;
`ifdef MEM_ARB_REG_RESP_EN
    resp_data_d = resp_data_q;
    im_rv_d     = 1'b0;
    dm_rv_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (d_wins) begin
          state_d  = S_DREQ;
          addr_d   = dm_req_addr;
          wdata_d  = dm_req_wdata;
          wen_d    = dm_req_wen;
          valid_d  = 1'b1;
          if (!im_req_valid)                streak_d = 3'd0;
          else if (streak_q != STREAK_MAX)  streak_d = streak_q + 3'd1;
        end else if (im_req_valid) begin
          state_d  = S_IREQ;
          addr_d   = im_req_addr;
          wdata_d  = 64'd0;
          wen_d    = 1'b0;
          valid_d  = 1'b1;
          streak_d = 3'd0;
        end
      end
      // Request fields stay frozen while valid is high; transfer happens on valid && ready.
      S_IREQ: begin
        if (bus_req_ready) begin
          state_d = S_IWAIT;
          valid_d = 1'b0;
        end
      end
      S_DREQ: begin
        if (bus_req_ready) begin
          state_d = S_DWAIT;
          valid_d = 1'b0;
        end
      end
      S_IWAIT: begin
        if (bus_resp_valid) begin
`ifdef MEM_ARB_REG_RESP_EN
          state_d     = S_RESP;
          resp_data_d = bus_resp_rdata;
          im_rv_d     = 1'b1;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_DWAIT: begin
        if (bus_resp_valid) begin
`ifdef MEM_ARB_REG_RESP_EN
          state_d     = S_RESP;
          resp_data_d = bus_resp_rdata;
          dm_rv_d     = 1'b1;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef MEM_ARB_REG_RESP_EN
      S_RESP: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      streak_q <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      wen_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef MEM_ARB_REG_RESP_EN
      resp_data_q <= 64'd0;
      im_rv_q     <= 1'b0;
      dm_rv_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      valid_q  <= valid_d;
`ifdef MEM_ARB_REG_RESP_EN
      resp_data_q <= resp_data_d;
      im_rv_q     <= im_rv_d;
      dm_rv_q     <= dm_rv_d;
`endif
    end
  end

  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_wen   = wen_q;
  assign bus_req_valid = valid_q;
  assign dbg_state     = state_q;
  assign dbg_streak    = streak_q;

`ifdef MEM_ARB_REG_RESP_EN
  assign im_resp_valid = im_rv_q;
  assign dm_resp_valid = dm_rv_q;
  assign im_resp_rdata = resp_data_q;
  assign dm_resp_rdata = resp_data_q;
`else
  // Responses outside a wait state never qualify, which drops spurious bus pulses.
  assign im_resp_valid = (state_q == S_IWAIT) && bus_resp_valid;
  assign dm_resp_valid = (state_q == S_DWAIT) && bus_resp_valid;
  assign im_resp_rdata = bus_resp_rdata;
  assign dm_resp_rdata = bus_resp_rdata;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb: reset, load, store, backpressure, priority/streak, spurious responses.
module tb_mem_arb;

`ifdef MEM_ARB_REG_RESP_EN
  localparam bit REG_RESP = 1'b1;
`else
  localparam bit REG_RESP = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_IREQ  = 3'd1;
  localparam logic [2:0] ST_IWAIT = 3'd2;
  localparam logic [2:0] ST_DREQ  = 3'd3;
  localparam logic [2:0] ST_DWAIT = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic [63:0] dm_req_addr;
  logic [63:0] dm_req_wdata;
  logic        dm_req_wen;
  logic        dm_req_valid;
  logic [63:0] dm_resp_rdata;
  logic        dm_resp_valid;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic        bus_req_wen;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_resp_rdata;
  logic        bus_resp_valid;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_streak;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  mem_arb #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .im_req_addr(im_req_addr), .im_req_valid(im_req_valid),
    .im_resp_rdata(im_resp_rdata), .im_resp_valid(im_resp_valid),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wen(dm_req_wen),
    .dm_req_valid(dm_req_valid),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wen(bus_req_wen),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_resp_rdata(bus_resp_rdata), .bus_resp_valid(bus_resp_valid),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: pop the expected read data and check the pulse lands on the owner only.
  task automatic check_resp(input bit is_dm);
    logic [63:0] exp_rd;
    exp_rd = exp_q.pop_front();
    check_eq("owner_resp_valid", is_dm ? dm_resp_valid : im_resp_valid, 64'd1);
    check_eq("other_resp_valid", is_dm ? im_resp_valid : dm_resp_valid, 64'd0);
    check_eq("resp_rdata", is_dm ? dm_resp_rdata : im_resp_rdata, exp_rd);
  endtask

  // Driver: one full transaction starting in IDLE at posedge+1, ending back in IDLE.
  task automatic do_txn(input bit is_dm, input logic [63:0] addr, input logic [63:0] wdata,
                        input bit wen, input int stall, input int lat, input logic [63:0] rd);
    exp_q.push_back(rd);
    if (is_dm) begin
      dm_req_valid = 1'b1; dm_req_addr = addr; dm_req_wdata = wdata; dm_req_wen = wen;
    end else begin
      im_req_valid = 1'b1; im_req_addr = addr;
    end
    tick();
    check_eq("req_state", dbg_state, is_dm ? ST_DREQ : ST_IREQ);
    check_eq("bus_req_valid", bus_req_valid, 64'd1);
    check_eq("bus_req_addr", bus_req_addr, addr);
    check_eq("bus_req_wen", bus_req_wen, is_dm ? 64'(wen) : 64'd0);
    check_eq("bus_req_wdata", bus_req_wdata, is_dm ? wdata : 64'd0);
    for (int i = 0; i < stall; i++) begin
      if (is_dm) dm_req_addr = addr ^ 64'hF0;
      tick();
      check_eq("stall_valid_held", bus_req_valid, 64'd1);
      check_eq("stall_addr_held", bus_req_addr, addr);
    end
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    #1;
    check_eq("wait_state", dbg_state, is_dm ? ST_DWAIT : ST_IWAIT);
    check_eq("wait_req_valid", bus_req_valid, 64'd0);
    for (int i = 1; i < lat; i++) tick();
    bus_resp_valid = 1'b1;
    bus_resp_rdata = rd;
    if (REG_RESP) begin
      #1;
      check_eq("reg_no_early_pulse", is_dm ? dm_resp_valid : im_resp_valid, 64'd0);
      tick();
      bus_resp_valid = 1'b0;
      bus_resp_rdata = 64'd0;
    end
    #1;
    check_resp(is_dm);
    tick();
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 64'd0;
    if (is_dm) dm_req_valid = 1'b0; else im_req_valid = 1'b0;
    #1;
    check_eq("pulse_one_cycle", is_dm ? dm_resp_valid : im_resp_valid, 64'd0);
    check_eq("back_to_idle", dbg_state, ST_IDLE);
  endtask

  initial begin
    string order;
    int    exp_streak[10];
    int    budget;

    rst = 1'b0;
    im_req_addr = '0; im_req_valid = 1'b0;
    dm_req_addr = '0; dm_req_wdata = '0; dm_req_wen = 1'b0; dm_req_valid = 1'b0;
    bus_req_ready = 1'b0; bus_resp_rdata = '0; bus_resp_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_streak", dbg_streak, 64'd0);
    check_eq("rst_bus_valid", bus_req_valid, 64'd0);
    check_eq("rst_bus_addr", bus_req_addr, 64'd0);
    check_eq("rst_bus_wdata", bus_req_wdata, 64'd0);
    check_eq("rst_bus_wen", bus_req_wen, 64'd0);
    check_eq("rst_im_rv", im_resp_valid, 64'd0);
    check_eq("rst_dm_rv", dm_resp_valid, 64'd0);
    check_eq("rst_im_rdata", im_resp_rdata, 64'd0);
    check_eq("rst_dm_rdata", dm_resp_rdata, 64'd0);
    rst = 1'b1;
    tick();

    // single load, response two cycles after accept
    do_txn(1'b1, 64'h1000, 64'd0, 1'b0, 0, 2, 64'hDEADBEEF);
    // store
    do_txn(1'b1, 64'h2000, 64'h55AA, 1'b1, 0, 1, 64'h0);
    // fetch, wdata/wen forced to 0 on the bus
    do_txn(1'b0, 64'h3000, 64'd0, 1'b0, 0, 3, 64'hCAFE_F00D_1234_5678);
    // backpressure: 5 stall cycles, address change by requester ignored
    do_txn(1'b1, 64'h4000, 64'h1111, 1'b0, 5, 1, 64'hA5A5);

    // spurious response in IDLE
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h77;
    #1;
    check_eq("spur_idle_dm", dm_resp_valid, 64'd0);
    check_eq("spur_idle_im", im_resp_valid, 64'd0);
    tick();
    bus_resp_valid = 1'b0;
    #1;
    check_eq("spur_idle_state", dbg_state, ST_IDLE);
    check_eq("spur_idle_dm_late", dm_resp_valid, 64'd0);

    // spurious response in DREQ, then coincident with accept
    dm_req_valid = 1'b1; dm_req_addr = 64'h5000; dm_req_wen = 1'b0;
    tick();
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h88;
    #1;
    check_eq("spur_dreq_dm", dm_resp_valid, 64'd0);
    tick();
    #1;
    check_eq("spur_dreq_state", dbg_state, ST_DREQ);
    check_eq("spur_dreq_dm_late", dm_resp_valid, 64'd0);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    #1;
    check_eq("spur_accept_state", dbg_state, ST_DWAIT);
    check_eq("spur_accept_dm", dm_resp_valid, 64'd0);
    tick();
    check_eq("spur_accept_dm_next", dm_resp_valid, 64'd0);
    check_eq("spur_accept_still_wait", dbg_state, ST_DWAIT);
    exp_q.push_back(64'h99);
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h99;
    if (REG_RESP) begin
      tick();
      bus_resp_valid = 1'b0; bus_resp_rdata = 64'd0;
    end
    #1;
    check_resp(1'b1);
    tick();
    bus_resp_valid = 1'b0; bus_resp_rdata = 64'd0; dm_req_valid = 1'b0;
    tick();

    // priority and starvation: both requesters held valid
    order = "DDDDIDDDDI";
    exp_streak = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    im_req_valid = 1'b1; im_req_addr = 64'h6000;
    dm_req_valid = 1'b1; dm_req_addr = 64'h7000; dm_req_wen = 1'b0;
    for (int g = 0; g < 10; g++) begin
      tick();
      bus_resp_valid = 1'b0;
      budget = 0;
      while (dbg_state != ST_IREQ && dbg_state != ST_DREQ && budget < 10) begin
        tick();
        budget++;
      end
      check_eq("grant_timeout", 64'(budget < 10), 64'd1);
      check_eq($sformatf("grant_order_%0d", g), dbg_state, (order[g] == "D") ? ST_DREQ : ST_IREQ);
      check_eq($sformatf("streak_%0d", g), dbg_streak, 64'(exp_streak[g]));
      check_eq($sformatf("grant_addr_%0d", g), bus_req_addr, (order[g] == "D") ? 64'h7000 : 64'h6000);
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      bus_resp_valid = 1'b1; bus_resp_rdata = 64'(g);
    end
    tick();
    bus_resp_valid = 1'b0; bus_resp_rdata = 64'd0;
    im_req_valid = 1'b0; dm_req_valid = 1'b0;
    tick();
    tick();
    check_eq("prio_end_idle", dbg_state, ST_IDLE);

    // reset asserted mid-DWAIT, then a stale response arrives
    dm_req_valid = 1'b1; dm_req_addr = 64'h8000;
    tick();
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    check_eq("pre_rst_wait", dbg_state, ST_DWAIT);
    rst = 1'b0; dm_req_valid = 1'b0;
    #1;
    check_eq("mid_rst_state", dbg_state, ST_IDLE);
    check_eq("mid_rst_bus_addr", bus_req_addr, 64'd0);
    tick();
    rst = 1'b1;
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'd0;
    #1;
    check_eq("stale_dm_rv", dm_resp_valid, 64'd0);
    check_eq("stale_im_rv", im_resp_valid, 64'd0);
    tick();
    bus_resp_valid = 1'b0;
    #1;
    check_eq("stale_dm_rv_late", dm_resp_valid, 64'd0);
    check_eq("post_rst_state", dbg_state, ST_IDLE);
    check_eq("post_rst_bus_valid", bus_req_valid, 64'd0);
    check_eq("post_rst_dm_rdata", dm_resp_rdata, 64'd0);
    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port to one-port memory arbiter placed between the core's instruction-fetch port (`im_*`) and data port (`dm_*`) and a single shared memory bus (`bus_*`). It grants one requester at a time and latches that request onto the bus. It holds one transaction outstanding until the bus response returns, then routes the response back to the granted requester. Data has priority, and a streak limit guarantees fetch forward progress.

## Interface
- `MAX_D_STREAK`, 4: max consecutive data grants issued while a fetch is waiting; range 1..7.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `im_req_addr` input 64: fetch address.
- `im_req_valid` input 1: fetch request; held high until `im_resp_valid`.
- `im_resp_rdata` output 64: fetch data.
- `im_resp_valid` output 1: one-cycle fetch completion pulse.
- `dm_req_addr` input 64: data address.
- `dm_req_wdata` input 64: store data.
- `dm_req_wen` input 1: 1 = store, 0 = load.
- `dm_req_valid` input 1: data request; held high until `dm_resp_valid`.
- `dm_resp_rdata` output 64: load data.
- `dm_resp_valid` output 1: one-cycle data completion pulse, for loads and stores alike.
- `bus_req_addr` output 64: latched address.
- `bus_req_wdata` output 64: latched store data; 0 for fetch.
- `bus_req_wen` output 1: latched write enable; 0 for fetch.
- `bus_req_valid` output 1: bus request.
- `bus_req_ready` input 1: bus accepts request when high together with valid.
- `bus_resp_rdata` input 64: response data.
- `bus_resp_valid` input 1: one-cycle response pulse; at most one per accepted request.

## Operation
- **FSM states:** IDLE, IREQ, IWAIT, DREQ, DWAIT. With `MEM_ARB_REG_RESP_EN` defined, there is also a RESP state.
- **Grant in IDLE:**
  - Only `dm_req_valid` set → DREQ.
  - Only `im_req_valid` set → IREQ.
  - Both set → DREQ, unless `streak == MAX_D_STREAK`; then → IREQ.
  - Neither set → stay in IDLE.
- **Latch on grant:** at the grant edge, latch the winner's addr/wdata/wen into the bus request registers. Fetch latches wdata=0, wen=0.
- **Streak counter (3 bits):**
  - On a data grant with `im_req_valid` high: increment, saturating at `MAX_D_STREAK`.
  - On a fetch grant, or a data grant with `im_req_valid` low: clear to 0.
- **Request states:** IREQ/DREQ drive `bus_req_valid`=1. On `bus_req_ready`=1 → IWAIT/DWAIT. Latched fields stay stable until accepted.
- **Wait states:** IWAIT/DWAIT drive `bus_req_valid`=0. On `bus_resp_valid` → route the response to the owner, then go to IDLE (or to RESP when registered).
- **Unexpected responses:** `bus_resp_valid` in IDLE, IREQ or DREQ is ignored and dropped.
- **Requester changes while granted:** requester valid/addr changes after grant are ignored until IDLE.
- **Response data:**
  - The non-owner response valid stays 0.
  - The rdata outputs mirror `bus_resp_rdata` (pass-through) or the response register (registered), regardless of owner.

## Timing
- **Reset values:** state=IDLE, streak=0. All `bus_req_*` = 0, `im_resp_valid`=`dm_resp_valid`=0, both rdata outputs = 0.
- **Reset mid-transaction:** abandon immediately. A later `bus_resp_valid` arriving in IDLE is dropped.
- **Request timing:**
  - Cycle 0: requester valid seen in IDLE.
  - Cycle 1: `bus_req_valid`=1.
  - Earliest accept is in cycle 1.
- **Response latency:**
  - Pass-through: the resp_valid pulse is in the same cycle as `bus_resp_valid`. Minimum latency, request to response, is 2 cycles plus bus latency.
  - Registered: the pulse is 1 cycle later.
- **Back-to-back:** the arbiter is in IDLE the cycle after the resp pulse (the cycle after RESP when registered). A requester may drop valid or raise a new request in that cycle.
- **Throughput:** one transaction per (bus latency + 2) cycles minimum.
- **Simultaneous events:** `bus_req_ready` and `bus_resp_valid` in the same cycle while in DREQ/IREQ → the response is ignored. The bus must not respond before acceptance.

## Configuration
- **`MEM_ARB_REG_RESP_EN` defined:**
  - Response data and owner are registered.
  - The resp_valid pulse comes one cycle after `bus_resp_valid`, via the RESP state.
  - rdata outputs hold the registered value.
- **Not defined:** the response is combinational pass-through and there is no RESP state.

## Test plan
- **Reset:** assert `rst`=0 mid-DWAIT, release, then pulse `bus_resp_valid` → no resp pulse, state IDLE, all outputs 0.
- **Single load:** dm load addr 0x1000, ready=1, response 0xDEADBEEF two cycles after accept → `bus_req_addr`=0x1000, wen=0, `dm_resp_rdata`=0xDEADBEEF with a 1-cycle pulse (delayed 1 cycle with the macro).
- **Store:** wdata 0x55AA, wen=1 → `bus_req_wdata`=0x55AA, `bus_req_wen`=1, `dm_resp_valid` pulses and `im_resp_valid` stays 0.
- **Bus backpressure:** `bus_req_ready`=0 for 5 cycles → `bus_req_valid` and addr held stable for 6 cycles, accept in the 6th.
- **Priority and starvation:** im and dm both held valid, `MAX_D_STREAK`=4 → grant order D,D,D,D,I,D…; the streak clears after the I grant.
- **Spurious response:** `bus_resp_valid` in IDLE and in DREQ → ignored, no resp pulse.
